// File: rtl/rand_range_sampler.sv
// rand_range_sampler
//   Turns the 32-bit random-word stream into uniform values in [0, limit-1]
//   using mask-and-reject sampling. After MAX_TRIES rejected draws the last
//   candidate is folded into range (C - L) and flagged as biased.
//
// Ports
//   clk        rising-edge clock
//   clr_n      asynchronous active-low reset
//   rnd_in     random word from the generator
//   rnd_valid  rnd_in holds a fresh word
//   rnd_ready  sampler consumes rnd_in this cycle (FETCH only)
//   req_valid  request present
//   req_limit  exclusive upper bound of the result (0 behaves as 1)
//   req_ready  sampler can accept a request (IDLE only)
//   out_valid  result available (DONE only)
//   out_data   sampled value, stable while out_valid
//   out_biased result came from the fallback path
//   out_ready  downstream takes the result
module rand_range_sampler #(
    parameter int WIDTH     = 16,
    parameter int MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [31:0]      rnd_in,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_limit,
    output logic             req_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_biased,
    input  logic             out_ready
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] mask_q,  mask_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             biased_q, biased_d;
    logic [WIDTH-1:0] cand;

    // Smallest 2^k-1 covering x: propagate the top set bit downwards.
    function automatic logic [WIDTH-1:0] smear(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] m;
        m = x;
        for (int unsigned s = 1; s < WIDTH; s = s * 2) begin
            m = m | (m >> s);
        end
        return m;
    endfunction

    generate
        if (WIDTH < 32) begin : g_unused
            logic unused_rnd_hi;
            assign unused_rnd_hi = ^rnd_in[31:WIDTH];
        end
    endgenerate

    assign cand = rnd_in[WIDTH-1:0] & mask_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            limit_q  <= '0;
            mask_q   <= '0;
            tries_q  <= '0;
            data_q   <= '0;
            biased_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            limit_q  <= limit_d;
            mask_q   <= mask_d;
            tries_q  <= tries_d;
            data_q   <= data_d;
            biased_q <= biased_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        limit_d  = limit_q;
        mask_d   = mask_q;
        tries_d  = tries_q;
        data_d   = data_q;
        biased_d = biased_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    limit_d = req_limit;
                    mask_d  = smear(req_limit - WIDTH'(1));
                    tries_d = '0;
                    if (req_limit <= WIDTH'(1)) begin
                        // Limits 0 and 1 have a single legal result; skip the draw.
                        data_d   = '0;
                        biased_d = 1'b0;
                        state_d  = DONE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (rnd_valid) begin
                    if (cand < limit_q) begin
                        data_d   = cand;
                        biased_d = 1'b0;
                        state_d  = DONE;
                    end else if (int'(tries_q) + 1 < MAX_TRIES) begin
                        tries_d = tries_q + TW'(1);
                    end else begin
                        // cand <= mask <= 2L-1, so cand-L is always in range.
                        data_d   = cand - limit_q;
                        biased_d = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign rnd_ready  = (state_q == FETCH);
    assign out_valid  = (state_q == DONE);
    assign out_data   = data_q;
    assign out_biased = biased_q;

endmodule

// File: tb/tb_rand_range_sampler.sv
module tb_rand_range_sampler;

    localparam int W  = 16;
    localparam int MT = 8;

    logic          clk        = 1'b0;
    logic          clr_n      = 1'b0;
    logic [31:0]   rnd_in     = '0;
    logic          rnd_valid  = 1'b0;
    logic          rnd_ready;
    logic          req_valid  = 1'b0;
    logic [W-1:0]  req_limit  = '0;
    logic          req_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_biased;
    logic          out_ready  = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] words [0:MT-1];

    rand_range_sampler #(
        .WIDTH     (W),
        .MAX_TRIES (MT)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .rnd_in     (rnd_in),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .req_valid  (req_valid),
        .req_limit  (req_limit),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_biased (out_biased),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    function automatic int unsigned mask_of(input int unsigned l);
        int unsigned m;
        m = 0;
        while (m < l - 1) m = m * 2 + 1;
        return m;
    endfunction

    // Reference: draw words in order, accept the first masked value below L,
    // fold the MT-th rejected value into range.
    function automatic void model(input int unsigned lim, output int unsigned d,
                                  output bit b, output int unsigned used);
        int unsigned l, m, c;
        l = (lim == 0) ? 1 : lim;
        d = 0; b = 0; used = 0;
        if (l == 1) return;
        m = mask_of(l);
        for (int i = 0; i < MT; i++) begin
            c = words[i] & m;
            used++;
            if (c < l) begin
                d = c;
                return;
            end
            if (i == MT - 1) begin
                d = c - l;
                b = 1;
                return;
            end
        end
    endfunction

    task automatic apply_reset();
        rnd_valid = 0; req_valid = 0; out_ready = 0;
        clr_n = 0;
        @(negedge clk);
        clr_n = 1;
        @(negedge clk);
    endtask

    // Entered and left at a negedge.
    task automatic run_txn(input int unsigned lim, input int gap_pct, input int hold, input string tag);
        int unsigned ed, eu, idx, lat;
        bit eb, seen;
        logic [W-1:0] held;
        model(lim, ed, eb, eu);

        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready_idle: got %b expected 1", tag, req_ready);
        end
        req_valid = 1; req_limit = W'(lim); rnd_valid = 0; out_ready = 0;
        @(posedge clk); @(negedge clk);
        req_valid = 0; req_limit = W'($urandom);

        idx = 0; lat = 0; seen = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            lat++;
            if (out_valid === 1'b1) begin
                seen = 1;
                break;
            end
            if (rnd_ready === 1'b1 && $urandom_range(99) >= gap_pct) begin
                rnd_valid = 1;
                rnd_in = (idx < MT) ? words[idx] : $urandom;
                idx++;
            end else begin
                rnd_valid = (rnd_ready === 1'b1) ? 1'b0 : 1'($urandom_range(1));
                rnd_in = $urandom;
            end
            @(posedge clk); @(negedge clk);
        end
        rnd_valid = 0;

        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: out_valid never rose (got 0 expected 1)", tag);
            apply_reset();
            return;
        end
        checks++;
        if (out_data !== W'(ed)) begin
            errors++;
            $display("FAIL %s data: got %0d expected %0d", tag, out_data, ed);
        end
        checks++;
        if (out_biased !== eb) begin
            errors++;
            $display("FAIL %s biased: got %b expected %b", tag, out_biased, eb);
        end
        checks++;
        if (idx != eu) begin
            errors++;
            $display("FAIL %s words_used: got %0d expected %0d", tag, idx, eu);
        end
        if (gap_pct == 0) begin
            checks++;
            if (lat != eu + 1) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", tag, lat, eu + 1);
            end
        end

        held = out_data;
        for (int h = 0; h < hold; h++) begin
            rnd_valid = ~rnd_valid;
            rnd_in = $urandom;
            @(posedge clk); @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== held || rnd_ready !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: got v=%b d=%0d rr=%b qr=%b expected v=1 d=%0d rr=0 qr=0",
                         tag, h, out_valid, out_data, rnd_ready, req_ready, held);
            end
        end
        rnd_valid = 0;

        out_ready = 1;
        @(posedge clk); @(negedge clk);
        out_ready = 0;
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s drain: got v=%b qr=%b expected v=0 qr=1", tag, out_valid, req_ready);
        end
    endtask

    task automatic fill_words(input logic [31:0] w);
        for (int i = 0; i < MT; i++) words[i] = w;
    endtask

    task automatic test_reset();
        clr_n = 0;
        #12;
        checks++;
        if (rnd_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_biased !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rr=%b v=%b d=%0d b=%b expected 0 0 0 0",
                     rnd_ready, out_valid, out_data, out_biased);
        end
        @(negedge clk);
        clr_n = 1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_reset_mid_fetch();
        req_valid = 1; req_limit = W'(10);
        @(posedge clk); @(negedge clk);
        req_valid = 0;
        rnd_valid = 1; rnd_in = 32'h0000_000F;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (rnd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_fetch: got rnd_ready=%b expected 1", rnd_ready);
        end
        #2 clr_n = 0;
        #1;
        checks++;
        if (rnd_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_immediate: got rr=%b v=%b expected 0 0", rnd_ready, out_valid);
        end
        @(negedge clk);
        clr_n = 1; rnd_valid = 0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: got qr=%b v=%b expected 1 0", req_ready, out_valid);
        end
        fill_words(32'hABCD_0003);
        run_txn(10, 0, 0, "after_midreset");
    endtask

    task automatic test_directed();
        fill_words(32'h0000_0007);
        run_txn(10, 0, 0, "l10_first");
        fill_words(32'h0000_0003);
        words[0] = 32'h0000_000C;
        run_txn(10, 0, 0, "l10_one_reject");
        fill_words(32'h0000_000F);
        run_txn(10, 0, 0, "l10_fallback");
        fill_words(32'hFFFF_FFFF);
        run_txn(1, 0, 0, "l1");
        run_txn(0, 0, 0, "l0");
        fill_words(32'h0000_FFFE);
        run_txn(32'hFFFF, 0, 0, "lmax_ok");
        fill_words(32'h0000_FFFF);
        run_txn(32'hFFFF, 0, 0, "lmax_fallback");
        fill_words(32'h1234_5673);
        words[0] = 32'h0000_0002;
        run_txn(2, 0, 0, "l2_reject");
    endtask

    task automatic test_hold();
        fill_words(32'h1234_5674);
        run_txn(10, 0, 5, "hold");
    endtask

    task automatic test_random();
        int unsigned lim, m;
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(3))
                0: lim = $urandom_range(3);
                1: lim = (32'd1 << $urandom_range(1, W - 1)) + $urandom_range(2) - 1;
                default: lim = $urandom_range(32'hFFFF);
            endcase
            m = mask_of((lim == 0) ? 1 : lim);
            for (int i = 0; i < MT; i++) begin
                words[i] = $urandom;
                if ($urandom_range(3) == 0 && lim >= 2 && m >= lim)
                    words[i] = (words[i] & ~m) | (lim + $urandom_range(m - lim));
            end
            if ($urandom_range(4) == 0) begin
                for (int i = 0; i < MT; i++)
                    if (lim >= 2 && m >= lim) words[i] = (words[i] & ~m) | (lim + $urandom_range(m - lim));
            end
            run_txn(lim, (t % 2 == 0) ? 0 : 40, $urandom_range(2), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid_fetch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
